// File: rtl/disp_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed common-cathode 7-segment display.
// Optional LEAD_ZERO_BLANK_EN suppresses leading zero digits 7..1.
module disp_scan_ctrl #(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        En,
  input  logic        UpdReq,
  input  logic [31:0] UpdData,
  input  logic [7:0]  UpdDp,
  output logic        UpdAck,
  output logic [2:0]  ScanIdx,
  output logic [7:0]  ComOut,
  output logic [7:0]  SegOut,
  output logic        FrameTick
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  logic [1:0]    state, nxt_state;
  logic [PW-1:0] presc, nxt_presc;
  logic [2:0]    nxt_idx;
  logic          frame_end;
  logic          nxt_tick;
  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;
  logic [3:0]    nib;
  logic [6:0]    seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    nxt_state = state;
    nxt_presc = presc;
    nxt_idx   = ScanIdx;
    frame_end = 1'b0;
    if (!En) begin
      nxt_state = S_IDLE;
      nxt_presc = '0;
      nxt_idx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          nxt_state = S_BLANK;
          nxt_presc = '0;
        end
        S_BLANK: begin
          nxt_presc = presc + 1'b1;
          if (presc == BLANK_LAST) nxt_state = S_DRIVE;
        end
        S_DRIVE: begin
          if (presc == PRESC_LAST) begin
            nxt_presc = '0;
            nxt_idx   = ScanIdx + 3'd1;
            nxt_state = S_BLANK;
            frame_end = (ScanIdx == 3'd7);
          end else begin
            nxt_presc = presc + 1'b1;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_presc = '0;
          nxt_idx   = '0;
        end
      endcase
    end
  end

  // FrameTick is registered one clock early so it is high during the final clock of digit 7.
  assign nxt_tick = (nxt_state == S_DRIVE) && (nxt_idx == 3'd7) && (nxt_presc == PRESC_LAST);
  assign nib      = shadow_data[{nxt_idx, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
  logic [7:0] lz_mask;
  logic       all_zero;

  // A digit is a leading zero when it and every higher digit hold 0; digit 0 always shows.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      all_zero   = all_zero && (shadow_data[i*4 +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  assign seg = lz_mask[nxt_idx] ? 7'h00 : seg_decode(nib);
`else
  assign seg = seg_decode(nib);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= S_IDLE;
      presc       <= '0;
      ScanIdx     <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      ComOut      <= 8'hFF;
      SegOut      <= 8'h00;
      UpdAck      <= 1'b0;
      FrameTick   <= 1'b0;
    end else begin
      state     <= nxt_state;
      presc     <= nxt_presc;
      ScanIdx   <= nxt_idx;
      ComOut    <= (nxt_state == S_DRIVE) ? ~(8'b1 << nxt_idx) : 8'hFF;
      SegOut    <= (nxt_state == S_DRIVE) ? {shadow_dp[nxt_idx], seg} : 8'h00;
      FrameTick <= nxt_tick;
      UpdAck    <= frame_end && UpdReq;
      // Capture only at frame end so a frame never mixes old and new data.
      if (frame_end && UpdReq) begin
        shadow_data <= UpdData;
        shadow_dp   <= UpdDp;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=1) using an
// expected-segment scoreboard popped as each digit is driven.
module tb_disp_scan_ctrl;

  localparam int CLK_DIV      = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int FRAME        = 8 * CLK_DIV;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        En;
  logic        UpdReq;
  logic [31:0] UpdData;
  logic [7:0]  UpdDp;
  logic        UpdAck;
  logic [2:0]  ScanIdx;
  logic [7:0]  ComOut;
  logic [7:0]  SegOut;
  logic        FrameTick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         digit;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];

  disp_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .CLK(CLK), .nRST(nRST), .En(En), .UpdReq(UpdReq), .UpdData(UpdData),
    .UpdDp(UpdDp), .UpdAck(UpdAck), .ScanIdx(ScanIdx), .ComOut(ComOut),
    .SegOut(SegOut), .FrameTick(FrameTick)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_seg(input logic [31:0] d, input logic [7:0] dp, input int i);
    logic [3:0] n;
    logic [6:0] s;
    n = d[i*4 +: 4];
    case (n)
      4'd0: s = 7'h3F;  4'd1: s = 7'h06;  4'd2: s = 7'h5B;  4'd3: s = 7'h4F;
      4'd4: s = 7'h66;  4'd5: s = 7'h6D;  4'd6: s = 7'h7D;  4'd7: s = 7'h07;
      4'd8: s = 7'h7F;  4'd9: s = 7'h6F;  default: s = 7'h00;
    endcase
    return {dp[i], s};
  endfunction

  task automatic push_frame(input logic [31:0] d, input logic [7:0] dp);
    for (int i = 0; i < 8; i++) exp_q.push_back('{i, ref_seg(d, dp, i)});
  endtask

  // Pops one expectation per digit as that digit is first driven; checks one-hot commons every clock.
  task automatic run_frame(input string name);
    exp_t e;
    int   n = 0;
    while (exp_q.size() > 0 && n < 3 * FRAME) begin
      total++;
      if ($countones(~ComOut) > 1) begin
        bad++;
        $display("FAIL %s onehot: ComOut=%h required at most one low bit", name, ComOut);
      end
      if (ComOut === ~(8'b1 << exp_q[0].digit)) begin
        e = exp_q.pop_front();
        total++;
        if (SegOut !== e.seg || ScanIdx !== 3'(e.digit)) begin
          bad++;
          $display("FAIL %s digit%0d: SegOut=%h ScanIdx=%0d required SegOut=%h ScanIdx=%0d",
                   name, e.digit, SegOut, ScanIdx, e.seg, e.digit);
        end
      end
      @(negedge CLK);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout: %0d digits never driven, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_request(input logic [31:0] d, input logic [7:0] dp, input string name);
    int n = 0;
    UpdReq  = 1'b1;
    UpdData = d;
    UpdDp   = dp;
    while (UpdAck !== 1'b1 && n < 2 * FRAME + 8) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (UpdAck !== 1'b1) begin
      bad++;
      $display("FAIL %s ack: UpdAck=%b required 1 within %0d clocks", name, UpdAck, 2 * FRAME + 8);
    end
    UpdReq = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_com [10] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFF, 8'hFB};
    logic [7:0] exp_seg;
    nRST = 1'b0; En = 1'b1; UpdReq = 1'b0; UpdData = '0; UpdDp = '0;
    repeat (2) @(negedge CLK);
    total++; if (ComOut !== 8'hFF) begin bad++; $display("FAIL reset ComOut: got %h required FF", ComOut); end
    total++; if (SegOut !== 8'h00) begin bad++; $display("FAIL reset SegOut: got %h required 00", SegOut); end
    total++; if (ScanIdx !== 3'd0) begin bad++; $display("FAIL reset ScanIdx: got %0d required 0", ScanIdx); end
    total++; if (UpdAck !== 1'b0) begin bad++; $display("FAIL reset UpdAck: got %b required 0", UpdAck); end
    total++; if (FrameTick !== 1'b0) begin bad++; $display("FAIL reset FrameTick: got %b required 0", FrameTick); end
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      exp_seg = (exp_com[i] == 8'hFF) ? 8'h00 : 8'h3F;
      total++;
      if (ComOut !== exp_com[i] || SegOut !== exp_seg) begin
        bad++;
        $display("FAIL startup cycle%0d: ComOut=%h SegOut=%h required ComOut=%h SegOut=%h",
                 i + 1, ComOut, SegOut, exp_com[i], exp_seg);
      end
    end
  endtask

  task automatic test_update();
    int   n = 0;
    logic early_ack = 1'b0;
    UpdReq = 1'b1; UpdData = 32'h87654321; UpdDp = 8'h04;
    do begin
      @(negedge CLK);
      n++;
      if (UpdAck === 1'b1) early_ack = 1'b1;
    end while (FrameTick !== 1'b1 && n < 2 * FRAME);
    total++; if (early_ack) begin bad++; $display("FAIL update early_ack: UpdAck=1 before frame end, required 0"); end
    total++; if (FrameTick !== 1'b1) begin bad++; $display("FAIL update tick_timeout: FrameTick=%b required 1", FrameTick); end
    total++;
    if (ScanIdx !== 3'd7 || ComOut !== 8'h7F) begin
      bad++;
      $display("FAIL update tick_pos: ScanIdx=%0d ComOut=%h required 7 and 7F", ScanIdx, ComOut);
    end
    @(negedge CLK);
    total++; if (UpdAck !== 1'b1) begin bad++; $display("FAIL update ack: got %b required 1", UpdAck); end
    UpdReq = 1'b0;
    @(negedge CLK);
    total++; if (UpdAck !== 1'b0) begin bad++; $display("FAIL update ack_width: got %b required 0", UpdAck); end
    push_frame(32'h87654321, 8'h04);
    run_frame("update");
  endtask

  task automatic test_blank_nibble();
    do_request(32'h9870A321, 8'h00, "nibbleA");
    push_frame(32'h9870A321, 8'h00);
    run_frame("nibbleA");
  endtask

  task automatic test_enable();
    int n = 0;
    while (ComOut !== 8'hDF && n < 2 * FRAME) begin @(negedge CLK); n++; end
    total++; if (ComOut !== 8'hDF) begin bad++; $display("FAIL enable find5: ComOut=%h required DF", ComOut); end
    En = 1'b0;
    @(negedge CLK);
    total++;
    if (ComOut !== 8'hFF || ScanIdx !== 3'd0 || SegOut !== 8'h00) begin
      bad++;
      $display("FAIL enable off: ComOut=%h ScanIdx=%0d SegOut=%h required FF 0 00", ComOut, ScanIdx, SegOut);
    end
    repeat (3) @(negedge CLK);
    total++; if (ComOut !== 8'hFF || UpdAck !== 1'b0) begin bad++; $display("FAIL enable hold: ComOut=%h UpdAck=%b required FF 0", ComOut, UpdAck); end
    En = 1'b1;
    @(negedge CLK);
    total++; if (ComOut !== 8'hFF || ScanIdx !== 3'd0) begin bad++; $display("FAIL enable gap: ComOut=%h ScanIdx=%0d required FF 0", ComOut, ScanIdx); end
    @(negedge CLK);
    total++; if (ComOut !== 8'hFE) begin bad++; $display("FAIL enable restart: ComOut=%h required FE", ComOut); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int k = 0;
    while (ComOut !== 8'h7F && n < 2 * FRAME) begin @(negedge CLK); n++; end
    total++; if (ComOut !== 8'h7F) begin bad++; $display("FAIL rstmid find7: ComOut=%h required 7F", ComOut); end
    UpdReq = 1'b1; UpdData = 32'h11111111; UpdDp = 8'hFF;
    nRST = 1'b0;
    @(negedge CLK);
    total++;
    if (ComOut !== 8'hFF || ScanIdx !== 3'd0 || UpdAck !== 1'b0) begin
      bad++;
      $display("FAIL rstmid reset: ComOut=%h ScanIdx=%0d UpdAck=%b required FF 0 0", ComOut, ScanIdx, UpdAck);
    end
    nRST = 1'b1;
    do begin
      @(negedge CLK);
      k++;
      if (k == 2) begin
        total++;
        if (ComOut !== 8'hFE || SegOut !== 8'h3F) begin
          bad++;
          $display("FAIL rstmid shadow0: ComOut=%h SegOut=%h required FE 3F", ComOut, SegOut);
        end
      end
    end while (UpdAck !== 1'b1 && k < 3 * FRAME);
    total++; if (k != FRAME + 1) begin bad++; $display("FAIL rstmid ack_time: ack after %0d clocks required %0d", k, FRAME + 1); end
    UpdReq = 1'b0;
    push_frame(32'h11111111, 8'hFF);
    run_frame("rstmid");
  endtask

  task automatic test_back_to_back();
    int   k = 0;
    logic extra = 1'b0;
    do_request(32'h11111111, 8'hFF, "b2b_first");
    UpdReq = 1'b1;
    do begin @(negedge CLK); k++; end while (UpdAck !== 1'b1 && k < 2 * FRAME);
    total++; if (k != FRAME) begin bad++; $display("FAIL b2b spacing: second ack after %0d clocks required %0d", k, FRAME); end
    UpdReq = 1'b0;
    repeat (FRAME + 2) begin @(negedge CLK); if (UpdAck === 1'b1) extra = 1'b1; end
    total++; if (extra) begin bad++; $display("FAIL b2b extra_ack: UpdAck=1 after UpdReq dropped, required 0"); end
  endtask

  task automatic test_lead_zero();
    logic [7:0] lead;
`ifdef LEAD_ZERO_BLANK_EN
    lead = 8'h00;
`else
    lead = 8'h3F;
`endif
    do_request(32'h00000105, 8'h00, "leadzero");
    exp_q.push_back('{0, 8'h6D});
    exp_q.push_back('{1, 8'h3F});
    exp_q.push_back('{2, 8'h06});
    for (int i = 3; i < 8; i++) exp_q.push_back('{i, lead});
    run_frame("leadzero");
  endtask

  initial begin
    test_reset();
    test_update();
    test_blank_nibble();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    test_lead_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Multiplexed-display scan controller for the 8-digit common-cathode 7-segment display in the digital clock.
- Sequences a 3-bit scan index through digits 0..7 at a prescaled rate and drives the active-low common lines with the same encoding as the common selector (ComOut[i]=0 only for the digit being driven).
- Decodes the selected BCD nibble to segments, inserts an anti-ghosting blank gap at each digit change, and accepts new display data from the timekeeping core only at frame boundaries, using a req/ack handshake.

Parameters:
- CLK_DIV, 1000, clocks per digit slot (>=2).
- BLANK_CYCLES, 2, clocks at start of each slot with all commons off (1..CLK_DIV-1).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- En  in  1  scan enable; 0 = display dark, scan held at digit 0.
- UpdReq  in  1  new display data pending; held high until UpdAck.
- UpdData  in  32  8 BCD digits, digit i = UpdData[4i+3:4i].
- UpdDp  in  8  decimal point per digit, active-high.
- UpdAck  out  1  one-clock pulse: UpdData/UpdDp captured into shadow.
- ScanIdx  out  3  current digit index 0..7.
- ComOut  out  8  active-low common select.
- SegOut  out  8  {dp,g,f,e,d,c,b,a}, active-high.
- FrameTick  out  1  one-clock pulse at end of digit 7 slot.

Behaviour:
- Reset, when nRST=0 at a rising CLK edge:
  - State=IDLE, prescaler=0, ScanIdx=0, shadow data=0, shadow DP=0.
  - ComOut=8'hFF, SegOut=8'h00, UpdAck=0, FrameTick=0.
  - Reset mid-slot or mid-handshake abandons the slot; a pending UpdReq is served at the next frame end.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: outputs dark. When En=1, go to BLANK with prescaler=0.
  - BLANK: ComOut=FF, SegOut=00. Prescaler increments each clock; at prescaler=BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: ComOut=~(8'b1<<ScanIdx), SegOut=decode(shadow nibble ScanIdx) with dp=shadow DP[ScanIdx]. When prescaler=CLK_DIV-1, the slot ends:
    - prescaler->0, ScanIdx->ScanIdx+1 mod 8 (7 wraps to 0), go to BLANK.
  - Slot length is exactly CLK_DIV clocks: BLANK_CYCLES blank, CLK_DIV-BLANK_CYCLES driven.
- En=0 in any state: the next clock goes to IDLE with ScanIdx=0, prescaler=0, outputs dark. No UpdAck is issued.
- Outputs are registered: ComOut/SegOut reflect state/ScanIdx one clock after the transition. Exactly one ComOut bit is low at any time, or none.
- Segment decode (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble 10..15 = 00 (blank). DP is still shown for these digits.
- Frame end is the clock on which the digit 7 slot ends. FrameTick=1 on that clock.
- If UpdReq=1 on the frame-end clock:
  - Shadow<=UpdData/UpdDp on that clock; UpdAck=1 the following clock only.
  - New data is displayed from digit 0 of the next frame, so no frame mixes old and new data.
- UpdReq rising mid-frame waits until frame end. UpdReq dropped before ack is a protocol violation; the block samples only at frame end.
- UpdReq held high across consecutive frame ends produces an ack per frame (level-sampled). The requester must drop UpdReq the clock after UpdAck.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: while decoding, digits 7 down to 1 whose nibble is 0 and all higher digits are 0 (in shadow) are blanked (SegOut segments=0; dp still honoured). Digit 0 is never blanked.
  - This is computed combinationally from shadow, so it changes only at shadow update.
- Undefined: every 0 nibble shows 3F; no extra logic.

Test Plan (CLK_DIV=4, BLANK_CYCLES=1):
1. nRST=0 two clocks with En=1 -> ComOut=FF, SegOut=00, ScanIdx=0, UpdAck=0. Release -> first DRIVE on digit 0 shows ComOut=FE, SegOut=3F; slot repeats every 4 clocks, with 1 clock FF between digits.
2. UpdReq=1, UpdData=32'h87654321, UpdDp=8'h04 mid-frame -> no ack until the digit 7 slot ends. Then FrameTick=1, UpdAck=1 next clock. Next frame: digit0 SegOut=06, digit2 SegOut=CF (4F|dp), digit7 SegOut=7F, ComOut for digit7=7F.
3. Shadow nibble=4'hA on digit 3 -> SegOut=00 during DRIVE with ComOut=F7; ComOut never has two bits low across a full frame (checked each clock).
4. En=0 during the digit 5 DRIVE -> next clock ComOut=FF, ScanIdx=0. En=1 -> scan restarts at digit 0 after 1 blank clock.
5. nRST=0 for one clock during digit 7 with UpdReq=1 -> shadow=0, no UpdAck. After one full frame, ack occurs at the first frame end.
6. With LEAD_ZERO_BLANK_EN and UpdData=32'h00000105 -> digits 7..3 SegOut=00, digit 2=06, digit 1=3F, digit 0=6D. Without the macro, digits 7..3 show 3F.
